// File: rtl/serial_collector.sv
// serial_collector: deserializes an LSB-first bit stream (the output of the
// bit-serial two's complementer) into WIDTH-bit parallel words, with a
// one-deep output slot guarded by a valid/ready handshake and a sticky
// overrun flag for completed frames that had nowhere to go.

module serial_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             inp,
  input  logic             clr_ovr,
  input  logic             ready,
  output logic [WIDTH-1:0] word_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  // Counter is just wide enough to address every bit of the frame.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_nxt;
  logic [WIDTH-1:0] frame_word;
  logic             complete;
  logic             slot_free;
  logic             drop;

  // Frame assembly: decide the next state, bit position and assembly
  // contents, and flag the cycle that carries the last bit of a frame.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    asm_nxt        = asm_q;
    complete       = 1'b0;
    frame_word     = asm_q;
    frame_word[cnt] = inp;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COLLECT;
          cnt_nxt   = CW'(1);
          asm_nxt   = {{(WIDTH-1){1'b0}}, inp};
        end
      end

      COLLECT: begin
        if (start) begin
          // A fresh start abandons whatever was partially collected.
          cnt_nxt = CW'(1);
          asm_nxt = {{(WIDTH-1){1'b0}}, inp};
        end else if (cnt == LAST_BIT) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          asm_nxt   = '0;
        end else begin
          asm_nxt = frame_word;
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        asm_nxt   = '0;
      end
    endcase
  end

  // The output slot can take a new word if it is empty or being drained now.
  always_comb begin
    slot_free = !valid || ready;
    drop      = complete && !slot_free;
  end

  // Collection state register: state, bit counter and assembly register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      asm_q <= asm_nxt;
    end
  end

  // Output slot: load completed words, retire consumed ones, and record drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        word_out <= frame_word;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_serial_collector.sv
// tb_serial_collector: directed stimulus for serial_collector (WIDTH=8),
// checked every cycle against a queue-based frame model and at key points
// against hand-computed literal values.

module tb_serial_collector;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             inp;
  logic             clr_ovr;
  logic             ready;
  logic [WIDTH-1:0] word_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;

  // Reference model state
  bit               bitq[$];
  logic [WIDTH-1:0] m_word  = '0;
  logic             m_valid = 1'b0;
  logic             m_ovr   = 1'b0;

  serial_collector #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .inp      (inp),
    .clr_ovr  (clr_ovr),
    .ready    (ready),
    .word_out (word_out),
    .valid    (valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is the list of bits seen since the last start;
  // once it holds WIDTH bits it becomes a word offered to the output slot.
  always @(posedge clk or negedge reset) begin
    logic [WIDTH-1:0] w;
    bit done;
    bit dropped;
    if (!reset) begin
      bitq.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      done    = 0;
      dropped = 0;
      w       = '0;
      if (start) begin
        bitq.delete();
        bitq.push_back(inp);
      end else if (bitq.size() > 0) begin
        bitq.push_back(inp);
      end
      if (bitq.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) w[i] = bitq[i];
        bitq.delete();
        done = 1;
      end
      if (done && (!m_valid || ready)) begin
        m_word  = w;
        m_valid = 1'b1;
      end else if (done) begin
        dropped = 1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (dropped) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (checking) begin
      cmp("model word_out", 32'(word_out), 32'(m_word));
      cmp("model valid", 32'(valid), 32'(m_valid));
      cmp("model busy", 32'(busy), 32'(bitq.size() > 0));
      cmp("model overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // One clock cycle with the given inputs; returns at the following negedge.
  task automatic applyStimulus(input logic s, input logic b, input logic r, input logic c);
    start   = s;
    inp     = b;
    ready   = r;
    clr_ovr = c;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] ew,
                             input logic ev, input logic eb, input logic eo);
    cmp({name, " word_out"}, 32'(word_out), 32'(ew));
    cmp({name, " valid"}, 32'(valid), 32'(ev));
    cmp({name, " busy"}, 32'(busy), 32'(eb));
    cmp({name, " overrun"}, 32'(overrun), 32'(eo));
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input logic r, input logic c);
    for (int i = 0; i < WIDTH; i++) applyStimulus(i == 0, w[i], r, c);
  endtask

  task automatic sendPartial(input logic [WIDTH-1:0] w, input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(i == 0, w[i], r, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] c3;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] comp;
    bit seen_one;

    start   = 1'b0;
    inp     = 1'b0;
    ready   = 1'b0;
    clr_ovr = 1'b0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    checking = 1;
    repeat (2) @(negedge clk);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Ready and data while idle with no start have no effect.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Single frame, consumer stalled, then drained.
    sendFrame(8'hA5, 1'b0, 1'b0);
    checkOutput("A5 done", 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("A5 hold", 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("A5 drained", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames with ready tied high.
    sendFrame(8'h3C, 1'b1, 1'b0);
    checkOutput("3C done", 8'h3C, 1'b1, 1'b0, 1'b0);
    c3 = 8'hC3;
    applyStimulus(1'b1, c3[0], 1'b1, 1'b0);
    checkOutput("C3 bit0", 8'h3C, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < WIDTH; i++) applyStimulus(1'b0, c3[i], 1'b1, 1'b0);
    checkOutput("C3 done", 8'hC3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("C3 drained", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Overrun: second word dropped, clear, then clear colliding with a drop.
    sendFrame(8'h11, 1'b0, 1'b0);
    checkOutput("11 done", 8'h11, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b0, 1'b0);
    checkOutput("22 dropped", 8'h11, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr cleared", 8'h11, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h33, 1'b0, 1'b1);
    checkOutput("clr vs drop", 8'h11, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("11 drained", 8'h11, 1'b0, 1'b0, 1'b0);

    // Restart at cycle 4 of a frame discards the partial bits silently.
    sendPartial(8'hFF, 4, 1'b1);
    checkOutput("partial", 8'h11, 1'b0, 1'b1, 1'b0);
    sendFrame(8'h7E, 1'b1, 1'b0);
    checkOutput("7E done", 8'h7E, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("7E drained", 8'h7E, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame with a word pending.
    sendFrame(8'h55, 1'b0, 1'b0);
    checkOutput("55 pending", 8'h55, 1'b1, 1'b0, 1'b0);
    sendPartial(8'hFF, 5, 1'b0);
    start = 1'b0;
    #2 reset = 1'b0;
    #1 checkOutput("async reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("in reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("after reset", 8'h00, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h0F, 1'b1, 1'b0);
    checkOutput("0F done", 8'h0F, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Stream from the bit-serial two's complementer fed 0x06.
    src      = 8'h06;
    seen_one = 0;
    for (int i = 0; i < WIDTH; i++) begin
      comp[i] = seen_one ? ~src[i] : src[i];
      if (src[i]) seen_one = 1;
    end
    sendFrame(comp, 1'b1, 1'b0);
    checkOutput("twos 06", 8'hFA, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("twos drained", 8'hFA, 1'b0, 1'b0, 1'b0);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
